// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the upstream adder, the accumulator and its consumer.
// Input side: start/in_sum/in_valid/in_ready; output side: out_*/busy.
interface sum_accumulator_if #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8
);
    logic             start;
    logic [IN_W-1:0]  in_sum;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_total;
    logic             out_ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start,
        output in_sum,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_total,
        input  out_ovf,
        input  out_valid,
        input  busy
    );

    modport slave (
        input  start,
        input  in_sum,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_total,
        output out_ovf,
        output out_valid,
        output busy
    );
endinterface

// File: rtl/sum_accumulator.sv
// Block accumulator: sums COUNT words per start pulse, flags carry-out.
// Define SUM_ACC_SATURATE_EN to clamp the total instead of wrapping.
module sum_accumulator #(
    parameter int IN_W  = 5,
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input logic            clk,
    input logic            rst_n,
    sum_accumulator_if.slave bus
);
    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] total;
    logic [CW-1:0]    cnt;
    logic             ovf;

    logic             clr;
    logic             accept;
    logic             in_ready;
    logic             out_valid;
    logic             last;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] total_add;

    assign last  = (cnt == CW'(COUNT - 1));
    assign sum   = {1'b0, total} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_sum};
    assign carry = sum[ACC_W];

`ifdef SUM_ACC_SATURATE_EN
    assign total_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign total_add = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        clr       = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = ACC;
                    clr       = 1'b1;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
                if (accept && last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Once a carry is seen the flag holds until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clr) begin
            total <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (accept) begin
            total <= total_add;
            cnt   <= cnt + 1'b1;
            ovf   <= ovf | carry;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_total = total;
    assign bus.out_ovf   = ovf;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_sum_accumulator.sv
// Randomised bench for sum_accumulator: three instances (defaults,
// ACC_W=6, COUNT=2) checked against a plain-arithmetic block model.
module tb_sum_accumulator;
    localparam int N = 3;

    logic clk;
    logic rst_n;

    logic [N-1:0]      start_v;
    logic [N-1:0]      in_valid_v;
    logic [N-1:0]      out_ready_v;
    logic [N-1:0][4:0] in_sum_v;
    logic [N-1:0]      in_ready_v;
    logic [N-1:0]      out_valid_v;
    logic [N-1:0]      out_ovf_v;
    logic [N-1:0]      busy_v;
    logic [N-1:0][7:0] total_v;

    int nchk;
    int nbad;

    sum_accumulator_if #(.IN_W(5), .ACC_W(8)) ia ();
    sum_accumulator_if #(.IN_W(5), .ACC_W(6)) ib ();
    sum_accumulator_if #(.IN_W(5), .ACC_W(8)) ic ();

    sum_accumulator #(.IN_W(5), .ACC_W(8), .COUNT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia)
    );
    sum_accumulator #(.IN_W(5), .ACC_W(6), .COUNT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib)
    );
    sum_accumulator #(.IN_W(5), .ACC_W(8), .COUNT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ic)
    );

    assign ia.start     = start_v[0];
    assign ia.in_valid  = in_valid_v[0];
    assign ia.out_ready = out_ready_v[0];
    assign ia.in_sum    = in_sum_v[0];
    assign in_ready_v[0]  = ia.in_ready;
    assign out_valid_v[0] = ia.out_valid;
    assign out_ovf_v[0]   = ia.out_ovf;
    assign busy_v[0]      = ia.busy;
    assign total_v[0]     = ia.out_total;

    assign ib.start     = start_v[1];
    assign ib.in_valid  = in_valid_v[1];
    assign ib.out_ready = out_ready_v[1];
    assign ib.in_sum    = in_sum_v[1];
    assign in_ready_v[1]  = ib.in_ready;
    assign out_valid_v[1] = ib.out_valid;
    assign out_ovf_v[1]   = ib.out_ovf;
    assign busy_v[1]      = ib.busy;
    assign total_v[1]     = {2'b00, ib.out_total};

    assign ic.start     = start_v[2];
    assign ic.in_valid  = in_valid_v[2];
    assign ic.out_ready = out_ready_v[2];
    assign ic.in_sum    = in_sum_v[2];
    assign in_ready_v[2]  = ic.in_ready;
    assign out_valid_v[2] = ic.out_valid;
    assign out_ovf_v[2]   = ic.out_ovf;
    assign busy_v[2]      = ic.busy;
    assign total_v[2]     = ic.out_total;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int acc_w_of(input int d);
        return (d == 1) ? 6 : 8;
    endfunction

    function automatic int count_of(input int d);
        return (d == 2) ? 2 : 4;
    endfunction

    // Block total from the rules: integer sum, wrap or clamp at 2^ACC_W.
    function automatic void model(input int d, input int beats[$],
                                  output int tot, output bit ovf);
        int lim;
        lim = 1 << acc_w_of(d);
        tot = 0;
        ovf = 1'b0;
        foreach (beats[i]) begin
            tot = tot + beats[i];
            if (tot >= lim) begin
                ovf = 1'b1;
`ifdef SUM_ACC_SATURATE_EN
                tot = lim - 1;
`else
                tot = tot - lim;
`endif
            end
        end
    endfunction

    task automatic run_block(input int d, input int beats[$], input int max_gap,
                             input int hold, input bit noise);
        int et;
        bit eo;
        model(d, beats, et, eo);
        nchk++;
        if (busy_v[d] !== 1'b0) begin
            nbad++;
            $display("FAIL idle_busy d=%0d got=%b exp=0", d, busy_v[d]);
        end
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        nchk++;
        if ({busy_v[d], in_ready_v[d], out_valid_v[d]} !== 3'b110) begin
            nbad++;
            $display("FAIL start_acc d=%0d got=%b exp=110", d,
                     {busy_v[d], in_ready_v[d], out_valid_v[d]});
        end
        foreach (beats[i]) begin
            repeat ($urandom_range(max_gap, 0)) begin
                in_valid_v[d] = 1'b0;
                in_sum_v[d]   = 5'($urandom);
                start_v[d]    = noise & 1'($urandom);
                @(negedge clk);
            end
            nchk++;
            if ({in_ready_v[d], out_valid_v[d]} !== 2'b10) begin
                nbad++;
                $display("FAIL beat_ready d=%0d beat=%0d got=%b exp=10", d, i,
                         {in_ready_v[d], out_valid_v[d]});
            end
            in_valid_v[d] = 1'b1;
            in_sum_v[d]   = 5'(beats[i]);
            start_v[d]    = noise;
            @(negedge clk);
        end
        in_valid_v[d] = 1'b0;
        start_v[d]    = noise;
        nchk++;
        if ({out_valid_v[d], in_ready_v[d], busy_v[d]} !== 3'b101) begin
            nbad++;
            $display("FAIL done_latency d=%0d got=%b exp=101", d,
                     {out_valid_v[d], in_ready_v[d], busy_v[d]});
        end
        nchk++;
        if (total_v[d] !== 8'(et) || out_ovf_v[d] !== eo) begin
            nbad++;
            $display("FAIL result d=%0d got=%0d/%b exp=%0d/%b", d,
                     total_v[d], out_ovf_v[d], et, eo);
        end
        repeat (hold) begin
            @(negedge clk);
            nchk++;
            if ({out_valid_v[d], busy_v[d], in_ready_v[d]} !== 3'b110 ||
                total_v[d] !== 8'(et) || out_ovf_v[d] !== eo) begin
                nbad++;
                $display("FAIL hold d=%0d got=%b %0d/%b exp=110 %0d/%b", d,
                         {out_valid_v[d], busy_v[d], in_ready_v[d]},
                         total_v[d], out_ovf_v[d], et, eo);
            end
        end
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
        start_v[d]     = 1'b0;
        nchk++;
        if ({out_valid_v[d], busy_v[d]} !== 2'b00) begin
            nbad++;
            $display("FAIL exit d=%0d got=%b exp=00", d,
                     {out_valid_v[d], busy_v[d]});
        end
    endtask

    task automatic test_reset();
        for (int d = 0; d < N; d++) begin
            nchk++;
            if ({in_ready_v[d], out_valid_v[d], busy_v[d], out_ovf_v[d],
                 total_v[d]} !== 12'h000) begin
                nbad++;
                $display("FAIL reset d=%0d got=%h exp=000", d,
                         {in_ready_v[d], out_valid_v[d], busy_v[d],
                          out_ovf_v[d], total_v[d]});
            end
        end
    endtask

    task automatic test_basic();
        int q[$];
        q = {5, 10, 15, 20};
        run_block(0, q, 0, 0, 1'b0);
        nchk++;
        if (total_v[0] !== 8'd50 || out_ovf_v[0] !== 1'b0) begin
            nbad++;
            $display("FAIL basic_hold got=%0d/%b exp=50/0", total_v[0], out_ovf_v[0]);
        end
    endtask

    task automatic test_overflow();
        int q[$];
        q = {31, 31, 31, 31};
        run_block(1, q, 1, 1, 1'b0);
    endtask

    task automatic test_stall();
        int q[$];
        q = {1, 2, 3, 4};
        run_block(0, q, 3, 5, 1'b0);
    endtask

    task automatic test_start_ignored();
        int q[$];
        q = {9, 8, 7, 6};
        run_block(0, q, 2, 3, 1'b1);
        @(negedge clk);
        nchk++;
        if (busy_v[0] !== 1'b0) begin
            nbad++;
            $display("FAIL start_exit got=%b exp=0", busy_v[0]);
        end
        q = {2, 4, 6, 8};
        run_block(0, q, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int q[$];
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        in_sum_v[0] = 5'd3;
        @(negedge clk);
        in_sum_v[0] = 5'd4;
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        nchk++;
        if ({in_ready_v[0], out_valid_v[0], busy_v[0], out_ovf_v[0],
             total_v[0]} !== 12'h000) begin
            nbad++;
            $display("FAIL reset_mid got=%h exp=000",
                     {in_ready_v[0], out_valid_v[0], busy_v[0],
                      out_ovf_v[0], total_v[0]});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = {7, 7, 7, 7};
        run_block(0, q, 0, 0, 1'b0);
    endtask

    task automatic test_count2();
        int q[$];
        q = {0, 0};
        run_block(2, q, 0, 2, 1'b0);
    endtask

    task automatic test_random();
        int q[$];
        int d;
        for (int k = 0; k < 16; k++) begin
            d = (k % 3 == 2) ? 2 : int'($urandom_range(1, 0));
            q = {};
            for (int i = 0; i < count_of(d); i++) begin
                q.push_back(int'($urandom_range(31, 0)));
            end
            run_block(d, q, 2, int'($urandom_range(3, 0)), 1'($urandom));
            @(negedge clk);
        end
    endtask

    initial begin
        nchk = 0;
        nbad = 0;
        rst_n = 1'b0;
        start_v = '0;
        in_valid_v = '0;
        out_ready_v = '0;
        in_sum_v = '0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        @(negedge clk);
        test_overflow();
        @(negedge clk);
        test_stall();
        @(negedge clk);
        test_start_ignored();
        @(negedge clk);
        test_reset_mid();
        @(negedge clk);
        test_count2();
        @(negedge clk);
        test_random();
        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
